ts_int_conditioner: RTL and testbench
=====================================

Name: ts_int_conditioner

Overview:
- Sits directly upstream of the touch-screen edge-capture interrupt PIO. Cleans the raw active-low INT pin from the touch controller and drives that PIO's in_port.
- Function: synchronise, debounce, stretch to a minimum pulse width and rate-limit the pin, so that one clean falling edge is produced per genuine touch event.
- Carries its own small Avalon-MM slave for configuration, status and event/drop counters.

Parameters:
- FILTER_W, 16: width of the debounce length register and counter.
- HOLD_W, 20: width of the holdoff length register and counter.
- DEF_FILTER, 500: reset value of the debounce length, in clk cycles.
- DEF_HOLDOFF, 50000: reset value of the holdoff length, in clk cycles.
- MIN_PULSE, 8: minimum int_out_n low time, in cycles; legal range >= 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- raw_int_n  in  1  asynchronous touch-controller INT pin, active-low
- address  in  2  Avalon register select
- chipselect  in  1  Avalon chip select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- int_out_n  out  1  conditioned interrupt, active-low, registered; drives PIO in_port

Behaviour:
- Reset: clk is the clock; reset_n is asynchronous and active-low. Reset values:
  - readdata = 0, int_out_n = 1.
  - sync1, sync2, filt and filt_q = 1.
  - Counters = 0, state = IDLE, enable = 1.
  - filter_len = DEF_FILTER, holdoff_len = DEF_HOLDOFF.
- Synchroniser: two flops, raw_int_n -> sync1 -> sync2.
- Debounce, evaluated each edge:
  - sync2 == filt: dcnt <= 0.
  - Otherwise, if dcnt >= filter_len: filt <= sync2 and dcnt <= 0.
  - Otherwise: dcnt <= dcnt + 1.
  - filter_len = 0 means a single-cycle follow.
  - The comparison is >=, so writing a smaller filter_len mid-count toggles filt on the next edge.
- Edge detect: filt_q <= filt; fall = filt_q & ~filt.
- FSM states: IDLE, ASSERT, HELD, HOLDOFF. int_out_n is registered and low only in ASSERT and HELD.
  - IDLE: fall & enable -> ASSERT; pcnt <= 0; accepted++.
  - ASSERT: pcnt increments each cycle. At pcnt == MIN_PULSE-1 -> HELD if filt == 0, else -> HOLDOFF with hcnt <= 0.
  - HELD: filt == 1 -> HOLDOFF, hcnt <= 0.
  - HOLDOFF: int_out_n = 1. At hcnt >= holdoff_len -> IDLE, else hcnt++. With holdoff_len = 0 the block returns to IDLE the next cycle.
  - A level that is still low on re-entering IDLE is not an event; a new falling edge of filt is required.
- Latency: raw_int_n is first sampled low at edge 0. Then int_out_n falls at edge filter_len + 3. int_out_n low time is >= MIN_PULSE cycles.
- Drops: a fall while enable = 1 and state != IDLE increments dropped; the state is unaffected. A fall while enable = 0 is ignored and not counted.
- Enable cleared: the FSM goes to IDLE on the next edge and int_out_n = 1 on that edge. The debounce logic keeps running.
- Counters: accepted and dropped are 16-bit and saturate at 0xFFFF. A write to the COUNT register clears both. If an increment coincides with the clear, the result is 1 for that counter.
- Registers: reads are registered with 1-cycle latency; readdata is updated every cycle from address regardless of chipselect.
  - 0 CTRL: [0] enable (R/W), [8] sync2 (RO), [9] filt (RO), [13:12] state (RO; IDLE=0, ASSERT=1, HELD=2, HOLDOFF=3). Other bits read 0.
  - 1 FILTER: [FILTER_W-1:0] filter_len, R/W.
  - 2 HOLDOFF: [HOLD_W-1:0] holdoff_len, R/W.
  - 3 COUNT: [15:0] accepted, [31:16] dropped. Reads return the counts; any write clears both.
- Writes take effect on the write edge. The unused upper bits of writedata are ignored.
- Reset mid-operation forces all reset values immediately, including int_out_n = 1 asynchronously.

Test Plan:
- Reset, then read all four registers -> CTRL = 0x0000_0301, FILTER = 500, HOLDOFF = 50000, COUNT = 0. int_out_n = 1.
- filter_len = 4, holdoff_len = 10; raw_int_n driven low for 40 cycles -> int_out_n falls at edge 7 after first sample. It stays low until filt rises, at least 8 cycles. Then 11 high cycles in HOLDOFF. COUNT = 0x0000_0001.
- filter_len = 4; 3-cycle low glitches separated by 3-cycle highs, repeated 20 times -> filt never falls, int_out_n stays 1, COUNT = 0.
- filter_len = 0, holdoff_len = 100; two clean 20-cycle lows separated by 30 cycles high -> one pulse out, COUNT = 0x0001_0001. A third low 200 cycles later -> accepted = 2.
- raw_int_n pulse low for 1 effective cycle with filter_len = 0 -> int_out_n low for exactly 8 cycles (MIN_PULSE). Then HOLDOFF.
- Clear enable while in HELD -> int_out_n = 1 on the next edge, state reads 0. A COUNT write coinciding with an accepted event -> accepted reads 1. Assert reset_n mid-ASSERT -> int_out_n = 1 immediately.

Source files
------------

// File: rtl/ts_int_conditioner.sv
// Touch-screen INT conditioner: synchronise, debounce, stretch and rate-limit the raw
// active-low touch INT into one clean falling edge per touch, with a small Avalon-MM slave.
module ts_int_conditioner #(
  parameter int FILTER_W    = 16,
  parameter int HOLD_W      = 20,
  parameter int DEF_FILTER  = 500,
  parameter int DEF_HOLDOFF = 50000,
  parameter int MIN_PULSE   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        raw_int_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        int_out_n
);

  localparam int PCNT_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam int USED_W = (FILTER_W > HOLD_W) ? FILTER_W : HOLD_W;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(MIN_PULSE - 1);

  // IDLE wait for fall | ASSERT minimum low time | HELD low until filt releases | HOLDOFF rate limit
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HELD    = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  logic                r_sync1;
  logic                r_sync2;
  logic                r_filt;
  logic                r_filt_q;
  logic [FILTER_W-1:0] r_dcnt;
  logic [FILTER_W-1:0] r_filter_len;
  logic [HOLD_W-1:0]   r_holdoff_len;
  logic                r_enable;
  state_t              r_state;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [HOLD_W-1:0]   r_hcnt;
  logic                r_int_out_n;
  logic [15:0]         r_accepted;
  logic [15:0]         r_dropped;
  logic [31:0]         r_readdata;

  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_filter;
  logic        w_wr_holdoff;
  logic        w_wr_count;
  logic        w_fall;
  logic        w_accept;
  logic        w_drop;
  logic [31:0] w_ctrl;
  logic        w_unused;

  assign w_wr         = chipselect & ~write_n;
  assign w_wr_ctrl    = w_wr & (address == 2'd0);
  assign w_wr_filter  = w_wr & (address == 2'd1);
  assign w_wr_holdoff = w_wr & (address == 2'd2);
  assign w_wr_count   = w_wr & (address == 2'd3);

  assign w_fall   = r_filt_q & ~r_filt;
  assign w_accept = w_fall & r_enable & (r_state == S_IDLE);
  assign w_drop   = w_fall & r_enable & (r_state != S_IDLE);

  assign w_ctrl   = {18'b0, r_state, 2'b0, r_filt, r_sync2, 7'b0, r_enable};
  assign w_unused = &{1'b0, writedata[31:USED_W]};

  assign readdata  = r_readdata;
  assign int_out_n = r_int_out_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_q <= 1'b1;
      r_dcnt   <= '0;
    end else begin
      r_sync1  <= raw_int_n;
      r_sync2  <= r_sync1;
      r_filt_q <= r_filt;
      // >= so a shortened filter_len mid-count releases on the next edge
      if (r_sync2 == r_filt) begin
        r_dcnt <= '0;
      end else if (r_dcnt >= r_filter_len) begin
        r_filt <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + FILTER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable      <= 1'b1;
      r_filter_len  <= FILTER_W'(DEF_FILTER);
      r_holdoff_len <= HOLD_W'(DEF_HOLDOFF);
    end else begin
      if (w_wr_ctrl)    r_enable      <= writedata[0];
      if (w_wr_filter)  r_filter_len  <= writedata[FILTER_W-1:0];
      if (w_wr_holdoff) r_holdoff_len <= writedata[HOLD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_int_out_n <= 1'b1;
      r_pcnt      <= '0;
      r_hcnt      <= '0;
    end else if (!r_enable) begin
      r_state     <= S_IDLE;
      r_int_out_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state     <= S_ASSERT;
            r_int_out_n <= 1'b0;
            r_pcnt      <= '0;
          end
        end
        S_ASSERT: begin
          if (r_pcnt == PCNT_LAST) begin
            if (!r_filt) begin
              r_state <= S_HELD;
            end else begin
              r_state     <= S_HOLDOFF;
              r_int_out_n <= 1'b1;
              r_hcnt      <= '0;
            end
          end else begin
            r_pcnt <= r_pcnt + PCNT_W'(1);
          end
        end
        S_HELD: begin
          if (r_filt) begin
            r_state     <= S_HOLDOFF;
            r_int_out_n <= 1'b1;
            r_hcnt      <= '0;
          end
        end
        S_HOLDOFF: begin
          if (r_hcnt >= r_holdoff_len) begin
            r_state <= S_IDLE;
          end else begin
            r_hcnt <= r_hcnt + HOLD_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_int_out_n <= 1'b1;
        end
      endcase
    end
  end

  // A clear that lands on an event edge keeps that event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_accepted <= '0;
      r_dropped  <= '0;
    end else if (w_wr_count) begin
      r_accepted <= {15'b0, w_accept};
      r_dropped  <= {15'b0, w_drop};
    end else begin
      if (w_accept && (r_accepted != 16'hFFFF)) r_accepted <= r_accepted + 16'd1;
      if (w_drop && (r_dropped != 16'hFFFF))    r_dropped  <= r_dropped + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (address)
        2'd0: r_readdata <= w_ctrl;
        2'd1: r_readdata <= {{(32-FILTER_W){1'b0}}, r_filter_len};
        2'd2: r_readdata <= {{(32-HOLD_W){1'b0}}, r_holdoff_len};
        2'd3: r_readdata <= {r_dropped, r_accepted};
        default: r_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_int_conditioner.sv
// Bench for ts_int_conditioner: directed stimulus, a timeline-level reference model checked
// every cycle, plus literal expectations for latency, pulse width and register contents.
module tb_ts_int_conditioner;
  localparam int MIN_PULSE = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        raw_int_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        int_out_n;

  ts_int_conditioner dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw_int_n  (raw_int_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .int_out_n  (int_out_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: output described as busy/low phases with ages, not as the DUT's states.
  logic        m_sync1 = 1'b1, m_sync2 = 1'b1, m_filt = 1'b1, m_filt_q = 1'b1;
  int          m_run = 0, m_flen = 500, m_hlen = 50000;
  logic        m_en = 1'b1;
  logic        m_busy = 1'b0, m_low = 1'b0;
  int          m_low_age = 0, m_hold_age = 0;
  int          m_acc = 0, m_drp = 0;
  logic [31:0] m_rd = 32'd0;
  logic        m_int_n;
  logic        mt_fall, mt_wr, mt_acc, mt_drp;
  logic [1:0]  mt_st;

  assign m_int_n = !(m_busy && m_low);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sync1 = 1'b1; m_sync2 = 1'b1; m_filt = 1'b1; m_filt_q = 1'b1;
      m_run = 0; m_flen = 500; m_hlen = 50000; m_en = 1'b1;
      m_busy = 1'b0; m_low = 1'b0; m_low_age = 0; m_hold_age = 0;
      m_acc = 0; m_drp = 0; m_rd = 32'd0;
    end else begin
      mt_st = !m_busy ? 2'd0 : (m_low ? ((m_low_age < MIN_PULSE) ? 2'd1 : 2'd2) : 2'd3);
      case (address)
        2'd0: m_rd = {18'b0, mt_st, 2'b0, m_filt, m_sync2, 7'b0, m_en};
        2'd1: m_rd = m_flen;
        2'd2: m_rd = m_hlen;
        default: m_rd = (m_drp << 16) | m_acc;
      endcase
      mt_fall = m_filt_q && !m_filt;
      mt_wr   = chipselect && !write_n;
      mt_acc  = mt_fall && m_en && !m_busy;
      mt_drp  = mt_fall && m_en && m_busy;
      if (!m_en) begin
        m_busy = 1'b0; m_low = 1'b0;
      end else if (!m_busy) begin
        if (mt_fall) begin m_busy = 1'b1; m_low = 1'b1; m_low_age = 0; end
      end else if (m_low) begin
        m_low_age++;
        if (m_low_age >= MIN_PULSE && m_filt) begin m_low = 1'b0; m_hold_age = 0; end
      end else begin
        if (m_hold_age >= m_hlen) m_busy = 1'b0;
        else m_hold_age++;
      end
      if (mt_wr && address == 2'd3) begin
        m_acc = mt_acc ? 1 : 0;
        m_drp = mt_drp ? 1 : 0;
      end else begin
        if (mt_acc && m_acc < 65535) m_acc++;
        if (mt_drp && m_drp < 65535) m_drp++;
      end
      m_filt_q = m_filt;
      if (m_sync2 != m_filt) begin
        m_run++;
        if (m_run > m_flen) begin m_filt = m_sync2; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_sync2 = m_sync1;
      m_sync1 = raw_int_n;
      if (mt_wr) begin
        case (address)
          2'd0: m_en = writedata[0];
          2'd1: m_flen = writedata[15:0];
          2'd2: m_hlen = writedata[19:0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      check("int_out_n_vs_model", {31'b0, int_out_n}, {31'b0, m_int_n});
      check("readdata_vs_model", readdata, m_rd);
    end
  end

  int   n_pulses = 0;
  logic prev_out = 1'b1;
  always @(negedge clk) begin
    if (prev_out && !int_out_n) n_pulses++;
    prev_out = int_out_n;
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic drive(input logic lvl, input int n);
    raw_int_n = lvl;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;
  int fall_at, rise_at, glitch, p0, low_cnt;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    rd(2'd0, v); check("rst_ctrl", v, 32'h0000_0301);
    rd(2'd1, v); check("rst_filter", v, 32'd500);
    rd(2'd2, v); check("rst_holdoff", v, 32'd50000);
    rd(2'd3, v); check("rst_count", v, 32'd0);
    check("rst_int_out_n", {31'b0, int_out_n}, 32'd1);

    // single long touch: latency, low time, one accepted event
    wr(2'd1, 32'd4); wr(2'd2, 32'd10); wr(2'd3, 32'd0);
    @(negedge clk);
    address = 2'd0; raw_int_n = 1'b0; fall_at = -1; rise_at = -1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (k == 40) raw_int_n = 1'b1;
      if (!int_out_n && fall_at < 0) fall_at = k;
      else if (int_out_n && fall_at >= 0 && rise_at < 0) rise_at = k;
    end
    check("latency_edge", fall_at - 1, 32'd7);
    check("low_len_long", rise_at - fall_at, 32'd40);
    rd(2'd3, v); check("count_single", v, 32'h0000_0001);

    // short glitches never pass a 4-cycle filter
    wr(2'd3, 32'd0);
    address = 2'd0; glitch = 0;
    for (int g = 0; g < 20; g++) begin
      raw_int_n = 1'b0;
      repeat (3) begin @(negedge clk); if (!int_out_n) glitch++; end
      raw_int_n = 1'b1;
      repeat (3) begin @(negedge clk); if (!int_out_n) glitch++; end
    end
    check("glitch_out_low", glitch, 32'd0);
    rd(2'd3, v); check("glitch_count", v, 32'd0);

    // holdoff rate limiting: second touch dropped, third accepted
    wr(2'd1, 32'd0); wr(2'd2, 32'd100); wr(2'd3, 32'd0);
    address = 2'd0; p0 = n_pulses;
    drive(1'b0, 20); drive(1'b1, 30); drive(1'b0, 20); drive(1'b1, 200);
    check("holdoff_pulses", n_pulses - p0, 32'd1);
    rd(2'd3, v); check("count_drop", v, 32'h0001_0001);
    address = 2'd0;
    drive(1'b0, 20); drive(1'b1, 200);
    rd(2'd3, v); check("count_third", v, 32'h0001_0002);

    // one-cycle touch is stretched to MIN_PULSE
    address = 2'd0; low_cnt = 0;
    raw_int_n = 1'b0;
    @(negedge clk);
    raw_int_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!int_out_n) low_cnt++;
    end
    check("min_pulse_len", low_cnt, MIN_PULSE);
    drive(1'b1, 150);

    // enable cleared while HELD
    wr(2'd2, 32'd10);
    address = 2'd0;
    raw_int_n = 1'b0;
    for (int k = 0; k < 20 && int_out_n; k++) @(negedge clk);
    check("held_reached_low", {31'b0, int_out_n}, 32'd0);
    repeat (12) @(negedge clk);
    wr(2'd0, 32'd0);
    check("en_clr_still_low", {31'b0, int_out_n}, 32'd0);
    @(negedge clk);
    check("en_clr_out_high", {31'b0, int_out_n}, 32'd1);
    rd(2'd0, v); check("en_clr_ctrl", v, 32'h0000_0000);
    drive(1'b1, 10);
    wr(2'd0, 32'd1);
    drive(1'b1, 5);

    // COUNT clear on the same edge as an accepted event
    @(negedge clk);
    raw_int_n = 1'b0;
    repeat (3) @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd(2'd3, v); check("count_clr_coincide", v, 32'h0000_0001);
    drive(1'b1, 40);

    // asynchronous reset during ASSERT
    address = 2'd0;
    raw_int_n = 1'b0;
    for (int k = 0; k < 20 && int_out_n; k++) @(negedge clk);
    check("assert_reached_low", {31'b0, int_out_n}, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_async_out", {31'b0, int_out_n}, 32'd1);
    raw_int_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, v); check("post_rst_ctrl", v, 32'h0000_0301);
    rd(2'd1, v); check("post_rst_filter", v, 32'd500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
